// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache memory-side read bridge:
// AXI encodings, cache request size codes and the bridge FSM states.
package icache_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] SZ_B    = 2'd0;
  localparam logic [1:0] SZ_H    = 2'd1;
  localparam logic [1:0] SZ_LINE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DONE
  } bridge_state_t;

  // AXI ARSIZE for a cache request size; a line refill always uses full words.
  function automatic logic [2:0] ar_size(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_LINE: return SIZE_4B;
      default: return {1'b0, sz};
    endcase
  endfunction

endpackage

// File: rtl/icache_line_collector.sv
// Gathers AXI read beats into a word-indexed line buffer, tracks the beat
// count against the requested burst length and accumulates the error flag.
module icache_line_collector
  import icache_pkg::*;
#(
  parameter int offset_width = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_clear,
  input  logic                            i_wr,
  input  logic [31:0]                     i_data,
  input  logic [1:0]                      i_resp,
  input  logic                            i_last,
  input  logic [7:0]                      i_len,
  output logic                            o_done,
  output logic                            o_err,
  output logic [32*(2**offset_width)-1:0] o_line
);

  localparam int WORDS = 2**offset_width;

  logic [7:0]             r_cnt;
  logic                   r_err;
  logic [WORDS-1:0][31:0] r_line;

  logic w_at_len;
  logic w_bad;

  // The terminal beat is either the one carrying rlast or the arlen-th one;
  // any disagreement between the two marks the transfer as erroneous.
  assign w_at_len = (r_cnt == i_len);
  assign o_done   = i_wr & (i_last | w_at_len);
  assign w_bad    = (i_resp != RESP_OKAY) | (i_last != w_at_len);

  // Clear on a new burst, otherwise store each accepted beat at word[cnt].
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_line <= '0;
    end else if (i_wr) begin
      r_line[r_cnt[offset_width-1:0]] <= i_data;
      r_cnt <= r_cnt + 8'd1;
      if (w_bad) r_err <= 1'b1;
    end
  end

  assign o_err  = r_err;
  assign o_line = r_line;

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache refill bridge: turns one cache miss request into a single
// AXI4 read burst and returns the assembled line with a one-cycle dataOK.
module icache_axi_rd_bridge
  import icache_pkg::*;
#(
  parameter int         offset_width = 2,
  parameter logic [3:0] axi_id       = 4'd0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            icache_mem_req,
  input  logic [1:0]                      icache_mem_size,
  input  logic [31:0]                     icache_mem_addr,
  output logic                            mem_icache_addrOK,
  output logic                            mem_icache_dataOK,
  output logic [32*(2**offset_width)-1:0] mem_icache_data,
  output logic                            mem_icache_err,
  output logic [3:0]                      arid,
  output logic [31:0]                     araddr,
  output logic [7:0]                      arlen,
  output logic [2:0]                      arsize,
  output logic [1:0]                      arburst,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [3:0]                      rid,
  input  logic [31:0]                     rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready
);

  localparam logic [31:0] LINE_MASK = ~((32'd1 << (offset_width + 2)) - 32'd1);
  localparam logic [7:0]  LINE_LEN  = 8'((1 << offset_width) - 1);

  bridge_state_t r_state;
  logic          r_arvalid;
  logic [31:0]   r_araddr;
  logic [7:0]    r_arlen;
  logic [2:0]    r_arsize;
  logic [1:0]    r_arburst;
  logic          r_dataok;

  logic w_rready;
  logic w_beat;
  logic w_clear;
  logic w_done;
  logic w_unused_rid;

  // Only one transaction is ever outstanding, so the returned ID carries no
  // information.
  assign w_unused_rid = ^rid;

  // Stray beats are drained while idle; beats are refused while the address
  // is still pending and during the completion cycle.
  assign w_rready = ~rst & ((r_state == ST_IDLE) | (r_state == ST_R));
  assign w_beat   = (r_state == ST_R) & rvalid & w_rready;
  assign w_clear  = (r_state == ST_AR) & r_arvalid & arready;

  icache_line_collector #(
    .offset_width(offset_width)
  ) u_collector (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_clear),
    .i_wr   (w_beat),
    .i_data (rdata),
    .i_resp (rresp),
    .i_last (rlast),
    .i_len  (r_arlen),
    .o_done (w_done),
    .o_err  (mem_icache_err),
    .o_line (mem_icache_data)
  );

  // Request FSM with registered AR channel and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_dataok  <= 1'b0;
    end else begin
      r_dataok <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (icache_mem_req) begin
            r_arvalid <= 1'b1;
            r_arburst <= BURST_INCR;
            r_arsize  <= ar_size(icache_mem_size);
            if (icache_mem_size == SZ_LINE) begin
              r_araddr <= icache_mem_addr & LINE_MASK;
              r_arlen  <= LINE_LEN;
            end else begin
              r_araddr <= icache_mem_addr;
              r_arlen  <= 8'd0;
            end
            r_state <= ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_R;
          end
        end
        ST_R: begin
          if (w_done) begin
            r_dataok <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign arid              = axi_id;
  assign araddr            = r_araddr;
  assign arlen             = r_arlen;
  assign arsize            = r_arsize;
  assign arburst           = r_arburst;
  assign arvalid           = r_arvalid;
  assign rready            = w_rready;
  assign mem_icache_addrOK = r_arvalid & arready;
  assign mem_icache_dataOK = r_dataok;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Scoreboard bench for icache_axi_rd_bridge: a scripted AXI slave drives
// bursts, expected lines are queued as each burst starts and compared when
// the bridge raises dataOK.
module tb_icache_axi_rd_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         icache_mem_req = 1'b0;
  logic [1:0]   icache_mem_size = 2'd0;
  logic [31:0]  icache_mem_addr = 32'd0;
  logic         mem_icache_addrOK;
  logic         mem_icache_dataOK;
  logic [127:0] mem_icache_data;
  logic         mem_icache_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [3:0]   rid = 4'd0;
  logic [31:0]  rdata = 32'd0;
  logic [1:0]   rresp = 2'd0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [128:0] sb_q[$];

  icache_axi_rd_bridge #(.offset_width(2), .axi_id(4'd0)) dut (
    .clk(clk), .rst(rst),
    .icache_mem_req(icache_mem_req), .icache_mem_size(icache_mem_size),
    .icache_mem_addr(icache_mem_addr),
    .mem_icache_addrOK(mem_icache_addrOK), .mem_icache_dataOK(mem_icache_dataOK),
    .mem_icache_data(mem_icache_data), .mem_icache_err(mem_icache_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Completed lines are popped from the scoreboard at mid-cycle.
  always @(negedge clk) begin
    if (!rst && mem_icache_dataOK) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_dataok", 128'(1), 128'(0));
      end else begin
        logic [128:0] e;
        e = sb_q.pop_front();
        chk("line_data", mem_icache_data, e[127:0]);
        chk("line_err", 128'(mem_icache_err), 128'(e[128]));
      end
    end
  end

  // Present a request, hold arready low for ar_wait cycles, then handshake.
  task automatic issue_ar(input logic [1:0] size, input logic [31:0] addr, input int ar_wait,
                          input logic [31:0] e_addr, input logic [7:0] e_len, input logic [2:0] e_size);
    icache_mem_req = 1'b1; icache_mem_size = size; icache_mem_addr = addr; arready = 1'b0;
    step();
    for (int k = 0; k < ar_wait; k++) begin
      chk("arvalid_wait", 128'(arvalid), 128'(1));
      chk("araddr_wait", 128'(araddr), 128'(e_addr));
      chk("arlen_wait", 128'(arlen), 128'(e_len));
      chk("addrok_wait", 128'(mem_icache_addrOK), 128'(0));
      chk("rready_wait", 128'(rready), 128'(0));
      step();
    end
    arready = 1'b1;
    #1;
    chk("arvalid", 128'(arvalid), 128'(1));
    chk("addrok", 128'(mem_icache_addrOK), 128'(1));
    chk("araddr", 128'(araddr), 128'(e_addr));
    chk("arlen", 128'(arlen), 128'(e_len));
    chk("arsize", 128'(arsize), 128'(e_size));
    chk("arburst", 128'(arburst), 128'(2'b01));
    step();
    icache_mem_req = 1'b0; arready = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [31:0] base, input int last_at, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == last_at);
      rresp = (i == bad_idx) ? 2'b10 : 2'b00;
      #1;
      chk("rready_r", 128'(rready), 128'(1));
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0;
  endtask

  task automatic finish_txn(input logic [127:0] exp);
    chk("dataok_pulse", 128'(mem_icache_dataOK), 128'(1));
    chk("rready_done", 128'(rready), 128'(0));
    step();
    chk("dataok_low", 128'(mem_icache_dataOK), 128'(0));
    chk("data_hold", mem_icache_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] e;

    // Reset values
    step(); step();
    chk("rst_arvalid", 128'(arvalid), 128'(0));
    chk("rst_rready", 128'(rready), 128'(0));
    chk("rst_addrok", 128'(mem_icache_addrOK), 128'(0));
    chk("rst_dataok", 128'(mem_icache_dataOK), 128'(0));
    chk("rst_err", 128'(mem_icache_err), 128'(0));
    chk("rst_data", mem_icache_data, 128'(0));
    chk("rst_araddr", 128'(araddr), 128'(0));
    chk("rst_arlen", 128'(arlen), 128'(0));
    rst = 1'b0;
    #1;
    chk("idle_rready", 128'(rready), 128'(1));
    chk("arid", 128'(arid), 128'(0));
    step();

    // Line refill, immediate arready
    e = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    sb_q.push_back({1'b0, e});
    issue_ar(2'd2, 32'h1C00_0014, 0, 32'h1C00_0010, 8'd3, 3'b010);
    send_beats(4, 32'hA0, 3, -1);
    finish_txn(e);

    // Line refill with arready held low for 5 cycles
    e = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    sb_q.push_back({1'b0, e});
    issue_ar(2'd2, 32'h0000_1238, 5, 32'h0000_1230, 8'd3, 3'b010);
    send_beats(4, 32'hB0, 3, -1);
    finish_txn(e);

    // Uncached halfword fetch
    e = 128'h1234;
    sb_q.push_back({1'b0, e});
    issue_ar(2'd1, 32'h8000_0002, 0, 32'h8000_0002, 8'd0, 3'b001);
    send_beats(1, 32'h1234, 0, -1);
    finish_txn(e);

    // Error response on beat 1
    e = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    sb_q.push_back({1'b1, e});
    issue_ar(2'd2, 32'h0000_0040, 0, 32'h0000_0040, 8'd3, 3'b010);
    send_beats(4, 32'hC0, 3, 1);
    finish_txn(e);

    // Early rlast on beat 2: word3 stays zero
    e = {32'h0, 32'hD2, 32'hD1, 32'hD0};
    sb_q.push_back({1'b1, e});
    issue_ar(2'd2, 32'h0000_0080, 0, 32'h0000_0080, 8'd3, 3'b010);
    send_beats(3, 32'hD0, 2, -1);
    finish_txn(e);

    // Single byte fetch whose only beat lacks rlast
    e = 128'h55;
    sb_q.push_back({1'b1, e});
    issue_ar(2'd0, 32'h0000_0007, 0, 32'h0000_0007, 8'd0, 3'b000);
    send_beats(1, 32'h55, -1, -1);
    finish_txn(e);

    // Reset during beat 2 of a line refill
    issue_ar(2'd2, 32'h0000_0100, 0, 32'h0000_0100, 8'd3, 3'b010);
    send_beats(2, 32'hF0, 3, -1);
    rvalid = 1'b1; rdata = 32'hF2; rlast = 1'b0; rst = 1'b1;
    #1;
    chk("rst_beat_rready", 128'(rready), 128'(0));
    step();
    rst = 1'b0;
    chk("abort_arvalid", 128'(arvalid), 128'(0));
    chk("abort_dataok", 128'(mem_icache_dataOK), 128'(0));
    chk("abort_err", 128'(mem_icache_err), 128'(0));
    chk("abort_data", mem_icache_data, 128'(0));
    #1;
    chk("drain_rready2", 128'(rready), 128'(1));
    step();
    rdata = 32'hF3; rlast = 1'b1;
    #1;
    chk("drain_rready3", 128'(rready), 128'(1));
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_dataok", 128'(mem_icache_dataOK), 128'(0));
      step();
    end

    // Normal request after the aborted one
    e = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    sb_q.push_back({1'b0, e});
    issue_ar(2'd2, 32'h0000_020C, 0, 32'h0000_0200, 8'd3, 3'b010);
    send_beats(4, 32'hE0, 3, -1);
    finish_txn(e);

    step();
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
